// File: rtl/consumer_fifo.sv
// consumer_fifo: buffered pull-side consumer endpoint.
//   Issues a one-cycle request pulse to a producer and waits for a valid word.
//   Each returned word is captured into a DEPTH-entry FIFO, which the downstream
//   reader sees as first-word fall-through. The block also keeps a saturating
//   count of accepted words and a sticky flag for a producer that never answered.
//
// Ports:
//   consumer_fifo_iclk      in   clock, rising edge
//   consumer_fifo_irst      in   asynchronous active-high reset
//   consumer_fifo_req       out  request pulse to producer (high only in REQ)
//   consumer_fifo_valid     in   producer data valid (accepted only in WAIT)
//   consumer_fifo_data      in   producer data word
//   consumer_fifo_rd_en     in   downstream pop (ignored while empty)
//   consumer_fifo_rd_data   out  FIFO head
//   consumer_fifo_rd_valid  out  FIFO not empty
//   consumer_fifo_count     out  occupancy
//   consumer_fifo_consumed  out  total accepted words, saturating
//   consumer_fifo_timeout   out  sticky producer-timeout flag
//
// Optional macro: CONSUMER_FIFO_MONITOR_EN prints each accepted word in simulation.
module consumer_fifo #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       consumer_fifo_iclk,
  input  logic                       consumer_fifo_irst,
  output logic                       consumer_fifo_req,
  input  logic                       consumer_fifo_valid,
  input  logic [DATA_W-1:0]          consumer_fifo_data,
  input  logic                       consumer_fifo_rd_en,
  output logic [DATA_W-1:0]          consumer_fifo_rd_data,
  output logic                       consumer_fifo_rd_valid,
  output logic [$clog2(DEPTH):0]     consumer_fifo_count,
  output logic [CNT_W-1:0]           consumer_fifo_consumed,
  output logic                       consumer_fifo_timeout
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]     wptr_q, wptr_d;
  logic [PtrW-1:0]     rptr_q, rptr_d;
  logic [OccW-1:0]     count_q, count_d;
  logic [CNT_W-1:0]    consumed_q, consumed_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic                timeout_q, timeout_d;
  logic                wr_en;
  logic                pop;

  assign wr_en = (state_q == StWait) && consumer_fifo_valid;
  assign pop   = consumer_fifo_rd_en && (count_q != '0);

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        // Only request when a slot is free, so a returned word always fits.
        if (count_q < OccW'(DEPTH)) state_d = StReq;
      end
      StReq: begin
        state_d = StWait;
      end
      StWait: begin
        if (consumer_fifo_valid) begin
          state_d   = StIdle;
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
          state_d   = StIdle;
          tmo_cnt_d = '0;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wptr_d     = wr_en ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q;
    consumed_d = consumed_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_en && (consumed_q != '1)) consumed_d = consumed_q + 1'b1;
  end

  always_ff @(posedge consumer_fifo_iclk or posedge consumer_fifo_irst) begin
    if (consumer_fifo_irst) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      consumed_q <= '0;
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      consumed_q <= consumed_d;
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge consumer_fifo_iclk) begin
    if (wr_en) mem_q[wptr_q] <= consumer_fifo_data;
  end

  assign consumer_fifo_req      = (state_q == StReq);
  assign consumer_fifo_rd_data  = mem_q[rptr_q];
  assign consumer_fifo_rd_valid = (count_q != '0);
  assign consumer_fifo_count    = count_q;
  assign consumer_fifo_consumed = consumed_q;
  assign consumer_fifo_timeout  = timeout_q;

`ifdef CONSUMER_FIFO_MONITOR_EN
  always @(posedge consumer_fifo_iclk) begin
    if (!consumer_fifo_irst && wr_en) begin
      $display("data consumed : %b time=%0t occupancy=%0d", consumer_fifo_data, $time, count_d);
    end
  end
`endif

endmodule

// File: tb/tb_consumer_fifo.sv
module tb_consumer_fifo;
  localparam int DATA_W  = 4;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;
  localparam int S_IDLE = 0, S_REQ = 1, S_WAIT = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    req;
  logic                    valid;
  logic [DATA_W-1:0]       data;
  logic                    rd_en;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;
  logic [$clog2(DEPTH):0]  count;
  logic [CNT_W-1:0]        consumed;
  logic                    timeout;

  consumer_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .consumer_fifo_iclk    (clk),
    .consumer_fifo_irst    (rst),
    .consumer_fifo_req     (req),
    .consumer_fifo_valid   (valid),
    .consumer_fifo_data    (data),
    .consumer_fifo_rd_en   (rd_en),
    .consumer_fifo_rd_data (rd_data),
    .consumer_fifo_rd_valid(rd_valid),
    .consumer_fifo_count   (count),
    .consumer_fifo_consumed(consumed),
    .consumer_fifo_timeout (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO as a queue, handshake phase, waited cycles.
  logic [DATA_W-1:0] m_q[$];
  int                m_st;
  int                m_waited;
  int unsigned       m_consumed;
  bit                m_timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_req"}, 32'(req), 32'(m_st == S_REQ));
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(m_q.size() != 0));
    chk({tag, "_count"}, 32'(count), 32'(m_q.size()));
    chk({tag, "_consumed"}, 32'(consumed), m_consumed);
    chk({tag, "_timeout"}, 32'(timeout), 32'(m_timeout));
    if (m_q.size() != 0) chk({tag, "_rd_data"}, 32'(rd_data), 32'(m_q[0]));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_st       = S_IDLE;
    m_waited   = 0;
    m_consumed = 0;
    m_timeout  = 1'b0;
  endtask

  // Asserts reset away from the clock edge and checks outputs before any edge.
  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    rd_en = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r, input string tag);
    bit pop;
    bit acc;
    int nst;
    valid = v;
    data  = d;
    rd_en = r;
    pop = r && (m_q.size() != 0);
    acc = (m_st == S_WAIT) && v;
    nst = m_st;
    case (m_st)
      S_IDLE: if (m_q.size() < DEPTH) nst = S_REQ;
      S_REQ: begin
        nst = S_WAIT;
        m_waited = 0;
      end
      default: begin
        if (v) nst = S_IDLE;
        else begin
          m_waited++;
          if (m_waited == TIMEOUT) begin
            m_timeout = 1'b1;
            nst = S_IDLE;
          end
        end
      end
    endcase
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(d);
      if (m_consumed != (32'd1 << CNT_W) - 1) m_consumed++;
    end
    m_st = nst;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Producer answering every request on the cycle after req, until the FIFO holds n words.
  task automatic fill_to(input int n, inout int nxt, input string tag);
    bit v;
    for (int i = 0; i < 200 && m_q.size() < n; i++) begin
      v = (m_st == S_WAIT);
      step(v, DATA_W'(nxt), 1'b0, tag);
      if (v) nxt++;
    end
    chk({tag, "_reached"}, 32'(count), 32'(n));
  endtask

  initial begin
    int nxt;
    int saved;
    bit v;
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    rd_en = 1'b0;
    do_reset();

    // Pop while empty, then an idle producer until the timeout fires.
    step(1'b0, '0, 1'b1, "rd_empty");
    chk("rd_empty_count0", 32'(count), 32'd0);
    for (int i = 0; i < TIMEOUT + 6; i++) step(1'b0, '0, 1'b0, "idle_prod");
    chk("timeout_set", 32'(timeout), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, "timeout_sticky");
    do_reset();
    chk("timeout_cleared", 32'(timeout), 32'd0);

    // Fill to full with 1..8, then confirm no further requests.
    nxt = 1;
    fill_to(DEPTH, nxt, "fill");
    for (int i = 0; i < 6; i++) step(1'b1, 4'hf, 1'b0, "full_hold");
    chk("full_consumed", 32'(consumed), 32'd8);
    chk("full_head", 32'(rd_data), 32'h1);

    // One pop from full, refill with 9, then drain in order.
    step(1'b0, '0, 1'b1, "pop1");
    chk("pop1_head", 32'(rd_data), 32'h2);
    chk("pop1_count", 32'(count), 32'd7);
    fill_to(DEPTH, nxt, "refill");
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(rd_data), 32'(i + 2));
      step(1'b0, '0, 1'b1, "drain");
    end
    chk("drained_count", 32'(count), 32'd0);

    // Steady stream with the reader always popping.
    for (int i = 0; i < 40; i++) begin
      v = (m_st == S_WAIT);
      step(v, DATA_W'($urandom), 1'b1, "stream");
    end

    // Valid only outside WAIT must be dropped.
    saved = int'(m_consumed);
    for (int i = 0; i < 12; i++) begin
      v = (m_st != S_WAIT);
      step(v, 4'ha, 1'b0, "spurious");
    end
    chk("spurious_consumed", 32'(consumed), 32'(saved));

    // Reset in the middle of WAIT with three words buffered.
    do_reset();
    nxt = 3;
    fill_to(3, nxt, "pre_rst");
    for (int i = 0; i < 10 && m_st != S_WAIT; i++) step(1'b0, '0, 1'b0, "to_wait");
    chk("mid_wait_count3", 32'(count), 32'd3);
    do_reset();
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 1) == 1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
